// File: rtl/div_if.sv
`default_nettype none
// ============================================================================
// Module   : div_if
// Purpose  : Execute-stage divide request/response bundle (operands, annul,
//            stall, ready, {HI,LO} result).
// Revision : 1.0
// ============================================================================
interface div_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_div;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic                 annul;
    logic                 stall;
    logic                 ready;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, signed_div, opa, opb, annul,
        input  stall, ready, result
    );

    modport slave (
        input  start, signed_div, opa, opb, annul,
        output stall, ready, result
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Radix-2 restoring multi-cycle DIV/DIVU; result = {rem(HI), quo(LO)}.
//            Optional macro DIV_EARLY_OUT_EN: skip iteration when opb==0 or
//            |opa| < |opb|.
// Revision : 1.0
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    div_if.slave      bus
);
    localparam int c_CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]      r_rem;
    logic [WIDTH-1:0]      r_quo;
    logic [WIDTH-1:0]      r_absb;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_bzero;
    logic [2*WIDTH-1:0]    r_result;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_early;
    logic                  w_stall;
    logic                  w_ready;
    logic [WIDTH-1:0]      w_abs_a;
    logic [WIDTH-1:0]      w_abs_b;
    logic [WIDTH:0]        w_rem_sh;
    logic                  w_ge;
    logic [WIDTH-1:0]      w_rem_nx;
    logic [WIDTH-1:0]      w_quo_nx;
    logic [WIDTH-1:0]      w_q_fin;
    logic [WIDTH-1:0]      w_r_fin;

    assign w_abs_a  = (bus.signed_div && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
    assign w_abs_b  = (bus.signed_div && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;
    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.annul;
    assign w_last   = (r_cnt == c_CNT_W'(1));

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (bus.opb == '0) || (w_abs_a < w_abs_b);
`else
    assign w_early = 1'b0;
`endif

    // One restoring step: the partial remainder is one bit wider than the
    // divisor only transiently, right after the shift.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_absb});
    assign w_rem_nx = w_ge ? (w_rem_sh[WIDTH-1:0] - r_absb) : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

    // Divide by zero leaves |a| in the remainder, which the dividend sign fix
    // turns back into opa; the quotient is forced to all ones.
    assign w_q_fin = r_bzero ? '1 : (r_neg_q ? -w_quo_nx : w_quo_nx);
    assign w_r_fin = r_neg_r ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_stall = 1'b1;
                    w_next  = w_early ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                w_stall = !bus.annul;
                if (bus.annul) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_ready = 1'b1;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_absb   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_rem   <= '0;
            r_quo   <= w_abs_a;
            r_absb  <= w_abs_b;
            r_neg_q <= bus.signed_div && (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
            r_neg_r <= bus.signed_div && bus.opa[WIDTH-1];
            r_bzero <= (bus.opb == '0);
            r_cnt   <= c_CNT_W'(WIDTH);
            if (w_early) begin
                r_result <= {bus.opa, {WIDTH{bus.opb == '0}}};
            end
        end else if ((r_state == S_BUSY) && !bus.annul) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt - c_CNT_W'(1);
            if (w_last) begin
                r_result <= {w_r_fin, w_q_fin};
            end
        end
    end

    assign bus.stall  = w_stall;
    assign bus.ready  = w_ready;
    assign bus.result = r_result;
endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Directed + scoreboard bench for div_unit (latency, results, annul,
//            async reset, back-to-back).
// Revision : 1.0
// ============================================================================
module tb_div_unit;
    localparam int WIDTH = 32;

    typedef struct {
        logic [63:0] res;
        int          at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    div_if #(.WIDTH(WIDTH)) bus ();
    div_unit #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb_, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb_ = longint'($signed(b));
            q = sa / sb_;
            r = sa % sb_;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    function automatic int lat_of(input logic [31:0] a, input logic [31:0] b, input logic s);
`ifdef DIV_EARLY_OUT_EN
        logic [31:0] aa, bb;
        aa = (s && a[31]) ? -a : a;
        bb = (s && b[31]) ? -b : b;
        if (b == 32'd0 || aa < bb) return 1;
`endif
        return 33;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] e, input bit track);
        exp_t x;
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.signed_div = s;
        bus.opa        = a;
        bus.opb        = b;
        bus.annul      = 1'b0;
        if (track) begin
            x.res = e;
            x.at  = cyc + lat_of(a, b, s);
            sb.push_back(x);
        end
    endtask

    task automatic wait_ready(input int bound);
        exp_t e;
        bit   got;
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                got = 1'b1;
                if (sb.size() == 0) begin
                    chk("spurious_ready", {63'd0, bus.ready}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ready_cycle", 64'(cyc), 64'(e.at));
                    chk("result", bus.result, e.res);
                    chk("stall_in_done", {63'd0, bus.stall}, 64'd0);
                end
            end else begin
                chk("stall_busy", {63'd0, bus.stall}, 64'd1);
            end
        end
        chk("ready_timeout", {63'd0, got}, 64'd1);
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [63:0] e, input bit keep);
        drive(a, b, s, e, 1'b1);
        wait_ready(45);
        if (!keep) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.opa        = '0;
        bus.opb        = '0;
        bus.annul      = 1'b0;

        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_stall",  {63'd0, bus.stall}, 64'd0);
        chk("reset_ready",  {63'd0, bus.ready}, 64'd0);
        chk("reset_result", bus.result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Test-plan values
        op(32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 1'b0);
        op(32'hFFFF_FFF9, 32'h2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        op(32'h7, 32'hFFFF_FFFE, 1'b1, {32'h1, 32'hFFFF_FFFD}, 1'b0);
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 1'b0);
        op(32'd5, 32'd0, 1'b0, {32'h5, 32'hFFFF_FFFF}, 1'b0);
        op(32'hFFFF_FFFB, 32'd0, 1'b1, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b0);
        op(32'd3, 32'd10, 1'b0, {32'h3, 32'h0}, 1'b0);
        op(32'hFFFF_FFFD, 32'd10, 1'b1, {32'hFFFF_FFFD, 32'h0}, 1'b0);

        // Annul mid-BUSY: result stays {2,E}, restart at cycle 11 ends at 44
        op(32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 1'b0);
        drive(32'd100, 32'd7, 1'b0, 64'd0, 1'b0);
        repeat (10) begin
            @(negedge clk);
            chk("stall_pre_annul", {63'd0, bus.stall}, 64'd1);
        end
        @(posedge clk); #1;
        bus.annul = 1'b1;
        @(negedge clk);
        chk("annul_stall",  {63'd0, bus.stall}, 64'd0);
        chk("annul_ready",  {63'd0, bus.ready}, 64'd0);
        chk("annul_result", bus.result, {32'h2, 32'hE});
        drive(32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 1'b1);
        chk("annul_result_kept", bus.result, {32'h2, 32'hE});
        wait_ready(45);
        @(posedge clk); #1;
        bus.start = 1'b0;

        // Annul together with start in IDLE: never accepted
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.annul = 1'b1;
        bus.opa   = 32'd100;
        bus.opb   = 32'd7;
        @(negedge clk);
        chk("idle_annul_stall", {63'd0, bus.stall}, 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.annul = 1'b0;
        repeat (36) begin
            @(negedge clk);
            chk("idle_annul_no_ready", {63'd0, bus.ready}, 64'd0);
        end
        chk("idle_annul_result", bus.result, {32'h0, 32'h3});

        // Asynchronous reset mid-BUSY
        drive(32'd100, 32'd7, 1'b0, 64'd0, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        rst       = 1'b1;
        bus.start = 1'b0;
        #1;
        chk("rst_stall",  {63'd0, bus.stall}, 64'd0);
        chk("rst_ready",  {63'd0, bus.ready}, 64'd0);
        chk("rst_result", bus.result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        op(32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 1'b0);

        // Back-to-back with start held: ready at +33 and +67
        op(32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 1'b1);
        op(32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 1'b0);

        // Random operands against the reference model
        for (int k = 0; k < 8; k++) begin
            ra = $urandom;
            rb = (k % 3 == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
            rs = 1'($urandom_range(1, 0));
            if (k == 5) ra = ra & 32'h0000_000F;
            op(ra, rb, rs, model(ra, rb, rs), 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
